// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into click, double-click, long-press and auto-repeat pulses.
// Define BUTTON_EVENT_REPEAT_EN to build the auto-repeat generator; otherwise o_repeat is tied 0.
module button_event_decoder #(
    parameter int unsigned p_long   = 8,
    parameter int unsigned p_gap    = 4,
    parameter int unsigned p_repeat = 3
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_click,
    output logic o_double,
    output logic o_long,
    output logic o_repeat,
    output logic o_busy
);

    localparam int unsigned MaxLg  = (p_long > p_gap) ? p_long : p_gap;
    localparam int unsigned MaxAll = (MaxLg > p_repeat) ? MaxLg : p_repeat;
    localparam int unsigned CntW   = $clog2(MaxAll + 1);

    localparam logic [CntW-1:0] LongLast = CntW'(p_long - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(p_gap - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);

    typedef enum logic [2:0] {
        StArmed  = 3'd0,
        StIdle   = 3'd1,
        StPress1 = 3'd2,
        StGap    = 3'd3,
        StPress2 = 3'd4,
        StLong   = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            click_q, click_d;
    logic            double_q, double_d;
    logic            long_q, long_d;
    logic            busy_q, busy_d;

`ifdef BUTTON_EVENT_REPEAT_EN
    localparam logic [CntW-1:0] RepLast = CntW'(p_repeat - 1);
    logic repeat_q, repeat_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        click_d  = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
        repeat_d = 1'b0;
`endif
        case (state_q)
            // A button held through reset must be released before anything counts.
            StArmed: begin
                if (!i_in) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            StIdle: begin
                if (i_in) begin
                    state_d = StPress1;
                    cnt_d   = '0;
                end
            end
            StPress1: begin
                if (!i_in) begin
                    state_d = StGap;
                    cnt_d   = '0;
                end else if (cnt_q == LongLast) begin
                    state_d = StLong;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StGap: begin
                if (i_in) begin
                    state_d = StPress2;
                    cnt_d   = '0;
                end else if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    click_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end
            StPress2: begin
                if (!i_in) begin
                    state_d  = StIdle;
                    cnt_d    = '0;
                    double_d = 1'b1;
                end
            end
            StLong: begin
                if (!i_in) begin
                    state_d = StIdle;
                    cnt_d   = '0;
`ifdef BUTTON_EVENT_REPEAT_EN
                end else if (cnt_q == RepLast) begin
                    cnt_d    = '0;
                    repeat_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
`else
                end else begin
                    cnt_d = '0;
                end
`endif
            end
            default: begin
                state_d = StArmed;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == StPress1) || (state_d == StGap) ||
                 (state_d == StPress2) || (state_d == StLong);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StArmed;
            cnt_q    <= '0;
            click_q  <= 1'b0;
            double_q <= 1'b0;
            long_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            click_q  <= click_d;
            double_q <= double_d;
            long_q   <= long_d;
            busy_q   <= busy_d;
        end
    end

`ifdef BUTTON_EVENT_REPEAT_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            repeat_q <= 1'b0;
        end else begin
            repeat_q <= repeat_d;
        end
    end
    assign o_repeat = repeat_q;
`else
    assign o_repeat = 1'b0;
`endif

    assign o_click  = click_q;
    assign o_double = double_q;
    assign o_long   = long_q;
    assign o_busy   = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed gesture scenarios plus random levels against a
// run-length reference model. Honours BUTTON_EVENT_REPEAT_EN the same way as the design.
module tb_button_event_decoder;

    localparam int unsigned PLong   = 8;
    localparam int unsigned PGap    = 4;
    localparam int unsigned PRepeat = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in  = 1'b0;
    logic o_click, o_double, o_long, o_repeat, o_busy;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: gestures described by lengths of the current high/low runs.
    bit m_blocked = 1'b1;
    int m_ones    = 0;
    int m_zeros   = 0;
    int m_press   = 0;   // 0 none, 1 first press of a gesture, 2 second press
    bit m_islong  = 1'b0;
    bit e_click, e_double, e_long, e_repeat, e_busy;

    always #5 clk = ~clk;

    button_event_decoder #(
        .p_long  (PLong),
        .p_gap   (PGap),
        .p_repeat(PRepeat)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_in    (in),
        .o_click (o_click),
        .o_double(o_double),
        .o_long  (o_long),
        .o_repeat(o_repeat),
        .o_busy  (o_busy)
    );

    function automatic void model_update(input bit r, input bit v);
        e_click  = 1'b0;
        e_double = 1'b0;
        e_long   = 1'b0;
        e_repeat = 1'b0;
        e_busy   = 1'b0;
        if (r) begin
            m_blocked = 1'b1;
            m_ones    = 0;
            m_zeros   = 0;
            m_press   = 0;
            m_islong  = 1'b0;
        end else if (m_blocked) begin
            if (!v) begin
                m_blocked = 1'b0;
                m_ones    = 0;
                m_zeros   = 0;
                m_press   = 0;
            end
        end else if (v) begin
            if (m_ones == 0) begin
                if (m_press == 1 && !m_islong && m_zeros >= 1 && m_zeros <= int'(PGap)) begin
                    m_press = 2;
                end else begin
                    m_press  = 1;
                    m_islong = 1'b0;
                end
                m_ones  = 1;
                m_zeros = 0;
            end else begin
                m_ones++;
            end
            if (m_press == 1 && m_ones == int'(PLong) + 1) begin
                e_long   = 1'b1;
                m_islong = 1'b1;
            end
`ifdef BUTTON_EVENT_REPEAT_EN
            if (m_press == 1 && m_ones > int'(PLong) + 1 &&
                (m_ones - int'(PLong) - 1) % int'(PRepeat) == 0) begin
                e_repeat = 1'b1;
            end
`endif
            e_busy = 1'b1;
        end else begin
            m_ones = 0;
            if (m_zeros < 100000) m_zeros++;
            e_double = (m_press == 2) && (m_zeros == 1);
            e_click  = (m_press == 1) && !m_islong && (m_zeros == int'(PGap) + 1);
            e_busy   = (m_press == 1) && !m_islong && (m_zeros <= int'(PGap));
        end
    endfunction

    task automatic step(input bit r, input bit v);
        @(negedge clk);
        rst = r;
        in  = v;
        @(posedge clk);
        model_update(r, v);
        #1;
    endtask

    task automatic go_idle();
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_reset();
        int pulses;
        int busy_seen;
        pulses    = 0;
        busy_seen = 0;
        repeat (3) step(1'b1, 1'b1);
        n_checks++;
        if ({o_click, o_double, o_long, o_repeat, o_busy} !== 5'b0)
            $display("FAIL reset_outputs: got %b want 00000",
                     {o_click, o_double, o_long, o_repeat, o_busy});
        else n_pass++;
        repeat (20) begin
            step(1'b0, 1'b1);
            if (o_click || o_double || o_long || o_repeat) pulses++;
            if (o_busy) busy_seen++;
        end
        n_checks++;
        if (pulses !== 0) $display("FAIL held_after_reset_pulses: got %0d want 0", pulses);
        else n_pass++;
        n_checks++;
        if (busy_seen !== 0) $display("FAIL held_after_reset_busy: got %0d want 0", busy_seen);
        else n_pass++;
        step(1'b0, 1'b0);
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL armed_release_busy: got %b want 0", o_busy);
        else n_pass++;
        step(1'b0, 1'b1);
        n_checks++;
        if (o_busy !== 1'b1) $display("FAIL idle_after_release: got busy %b want 1", o_busy);
        else n_pass++;
        go_idle();
    endtask

    task automatic test_click();
        int click_cnt, click_at, dbl_cnt, long_cnt;
        click_cnt = 0;
        click_at  = -1;
        dbl_cnt   = 0;
        long_cnt  = 0;
        go_idle();
        repeat (3) begin
            step(1'b0, 1'b1);
            if (o_click) click_cnt++;
            if (o_double) dbl_cnt++;
            if (o_long) long_cnt++;
        end
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0);
            if (o_click) begin
                click_cnt++;
                click_at = k;
            end
            if (o_double) dbl_cnt++;
            if (o_long) long_cnt++;
        end
        n_checks++;
        if (click_cnt !== 1) $display("FAIL click_count: got %0d want 1", click_cnt);
        else n_pass++;
        n_checks++;
        if (click_at !== int'(PGap))
            $display("FAIL click_latency: got %0d want %0d", click_at, PGap);
        else n_pass++;
        n_checks++;
        if (dbl_cnt !== 0 || long_cnt !== 0)
            $display("FAIL click_others: got double %0d long %0d want 0 0", dbl_cnt, long_cnt);
        else n_pass++;
        n_checks++;
        if (o_busy !== 1'b0) $display("FAIL click_busy_end: got %b want 0", o_busy);
        else n_pass++;
    endtask

    task automatic test_double();
        bit pat [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        int click_cnt, dbl_cnt;
        click_cnt = 0;
        dbl_cnt   = 0;
        go_idle();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, pat[i]);
            if (o_click) click_cnt++;
            if (o_double) dbl_cnt++;
        end
        step(1'b0, 1'b0);
        n_checks++;
        if (o_double !== 1'b1) $display("FAIL double_pulse: got %b want 1", o_double);
        else n_pass++;
        if (o_double) dbl_cnt++;
        repeat (8) begin
            step(1'b0, 1'b0);
            if (o_click) click_cnt++;
            if (o_double) dbl_cnt++;
        end
        n_checks++;
        if (dbl_cnt !== 1) $display("FAIL double_count: got %0d want 1", dbl_cnt);
        else n_pass++;
        n_checks++;
        if (click_cnt !== 0) $display("FAIL double_no_click: got %0d want 0", click_cnt);
        else n_pass++;
    endtask

    task automatic test_long();
        int long_cnt, long_at, rep_cnt, rep_first, rep_want, click_cnt;
        long_cnt  = 0;
        long_at   = -1;
        rep_cnt   = 0;
        rep_first = -1;
        rep_want  = 0;
        click_cnt = 0;
        go_idle();
        for (int j = 0; j < 20; j++) begin
            step(1'b0, 1'b1);
            if (o_long) begin
                long_cnt++;
                long_at = j;
            end
            if (o_repeat) begin
                rep_cnt++;
                if (rep_first < 0) rep_first = j;
            end
`ifdef BUTTON_EVENT_REPEAT_EN
            if (j > int'(PLong) && (j - int'(PLong)) % int'(PRepeat) == 0) rep_want++;
`endif
        end
        n_checks++;
        if (long_cnt !== 1 || long_at !== int'(PLong))
            $display("FAIL long_pulse: got count %0d at %0d want 1 at %0d",
                     long_cnt, long_at, PLong);
        else n_pass++;
        n_checks++;
        if (rep_cnt !== rep_want) $display("FAIL repeat_count: got %0d want %0d", rep_cnt, rep_want);
        else n_pass++;
`ifdef BUTTON_EVENT_REPEAT_EN
        n_checks++;
        if (rep_first !== int'(PLong + PRepeat))
            $display("FAIL repeat_first: got %0d want %0d", rep_first, PLong + PRepeat);
        else n_pass++;
`endif
        step(1'b0, 1'b0);
        n_checks++;
        if (o_busy !== 1'b0 || o_repeat !== 1'b0)
            $display("FAIL long_release: got busy %b repeat %b want 0 0", o_busy, o_repeat);
        else n_pass++;
        repeat (8) begin
            step(1'b0, 1'b0);
            if (o_click) click_cnt++;
        end
        n_checks++;
        if (click_cnt !== 0) $display("FAIL long_no_click: got %0d want 0", click_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_gap();
        go_idle();
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        repeat (4) step(1'b0, 1'b0);
        n_checks++;
        if (o_busy !== 1'b1) $display("FAIL gap_busy: got %b want 1", o_busy);
        else n_pass++;
        step(1'b1, 1'b1);
        n_checks++;
        if ({o_click, o_double, o_long, o_repeat, o_busy} !== 5'b0)
            $display("FAIL gap_reset_outputs: got %b want 00000",
                     {o_click, o_double, o_long, o_repeat, o_busy});
        else n_pass++;
        step(1'b0, 1'b1);
        n_checks++;
        if ({o_click, o_double, o_long, o_repeat, o_busy} !== 5'b0)
            $display("FAIL gap_reset_armed: got %b want 00000",
                     {o_click, o_double, o_long, o_repeat, o_busy});
        else n_pass++;
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        n_checks++;
        if (o_busy !== 1'b1) $display("FAIL gap_reset_rearm: got busy %b want 1", o_busy);
        else n_pass++;
        go_idle();
    endtask

    task automatic test_random();
        bit lvl;
        bit r;
        int len;
        int i;
        logic [4:0] got;
        logic [4:0] want;
        lvl = 1'b0;
        i   = 0;
        go_idle();
        while (i < 3000) begin
            lvl = ~lvl;
            len = $urandom_range(1, 14);
            for (int k = 0; k < len && i < 3000; k++) begin
                r = ($urandom_range(0, 99) == 0);
                step(r, lvl);
                got  = {o_click, o_double, o_long, o_repeat, o_busy};
                want = {e_click, e_double, e_long, e_repeat, e_busy};
                n_checks++;
                if (got !== want)
                    $display("FAIL random_step %0d: got %b want %b (click,double,long,repeat,busy)",
                             i, got, want);
                else n_pass++;
                i++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_click();
        test_double();
        test_long();
        test_reset_gap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
